// File: rtl/memory_access_stage_pkg.sv
// Shared encodings for the memory-access stage: store sizes, load funct3 codes,
// result-select codes and the access FSM states.
package memory_access_stage_pkg;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Access size of a load, expressed in the store-size encoding.
  function automatic logic [1:0] load_size(input logic [2:0] load_type);
    case (load_type[1:0])
      2'b00:   return MEM_BYTE;
      2'b01:   return MEM_HALF;
      default: return MEM_WORD;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_stage_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
  import memory_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (load_type)
      LT_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LT_LH:   data = {{16{half_sel[15]}}, half_sel};
      LT_LBU:  data = {24'h000000, byte_sel};
      LT_LHU:  data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: issues data-memory requests, stalls the front of
// the pipe while memory is busy, flags misalignment/timeouts and drives the M/W register.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [1:0]  MemWriteM,
  input  logic [2:0]  LoadTypeM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RDM,
  output logic [31:0] dmem_addr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        Stall_M,
  output logic        misalign_M,
  output logic        bus_err_M,
  output logic [2:0]  RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RDW,
  output state_e      state_dbg
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]    reg_write_w_q, reg_write_w_d;
  logic [1:0]    result_src_w_q, result_src_w_d;
  logic [31:0]   read_data_w_q, read_data_w_d;
  logic [31:0]   alu_result_w_q, alu_result_w_d;
  logic [31:0]   pc_plus4_w_q, pc_plus4_w_d;
  logic [4:0]    rd_w_q, rd_w_d;

  logic        is_load, is_store, mem_op, misaligned, complete, update_w;
  logic [1:0]  acc_size;
  logic [3:0]  lane_strb;
  logic [31:0] load_data;

  load_extend u_load_extend (
    .rdata     (dmem_rdata),
    .addr_lo   (ALUResultM[1:0]),
    .load_type (LoadTypeM),
    .data      (load_data)
  );

  always_comb begin
    is_load    = ResultSrcM == RES_MEM;
    is_store   = MemWriteM != MEM_NONE;
    mem_op     = is_load || is_store;
    acc_size   = is_store ? MemWriteM : load_size(LoadTypeM);
    misaligned = mem_op && (((acc_size == MEM_HALF) && ALUResultM[0]) ||
                            ((acc_size == MEM_WORD) && (ALUResultM[1:0] != 2'b00)));
    dmem_addr  = {ALUResultM[31:2], 2'b00};
    case (MemWriteM)
      MEM_BYTE: begin
        lane_strb  = 4'b0001 << ALUResultM[1:0];
        dmem_wdata = {4{WriteDataM[7:0]}};
      end
      MEM_HALF: begin
        lane_strb  = 4'b0011 << ALUResultM[1:0];
        dmem_wdata = {2{WriteDataM[15:0]}};
      end
      MEM_WORD: begin
        lane_strb  = 4'b1111;
        dmem_wdata = WriteDataM;
      end
      default: begin
        lane_strb  = 4'b0000;
        dmem_wdata = WriteDataM;
      end
    endcase
  end

  // Request/stall control. Ready beats the timeout when both land in one cycle.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    dmem_req   = 1'b0;
    Stall_M    = 1'b0;
    misalign_M = 1'b0;
    bus_err_M  = 1'b0;
    complete   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (misaligned) begin
          misalign_M = 1'b1;
        end else if (mem_op) begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            complete = 1'b1;
          end else begin
            Stall_M    = 1'b1;
            state_d    = ST_WAIT;
            wait_cnt_d = '0;
          end
        end
      end
      ST_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          bus_err_M = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          Stall_M    = 1'b1;
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      dmem_req   = 1'b0;
      Stall_M    = 1'b0;
      misalign_M = 1'b0;
      bus_err_M  = 1'b0;
    end
    dmem_we    = dmem_req && is_store;
    dmem_wstrb = dmem_we ? lane_strb : 4'b0000;

    // Anything that does not retire this cycle leaves a bubble behind.
    update_w       = complete || ((state_q == ST_IDLE) && !mem_op);
    reg_write_w_d  = update_w ? RegWriteM  : 3'b000;
    result_src_w_d = update_w ? ResultSrcM : result_src_w_q;
    read_data_w_d  = update_w ? load_data  : read_data_w_q;
    alu_result_w_d = update_w ? ALUResultM : alu_result_w_q;
    pc_plus4_w_d   = update_w ? PCPlus4M   : pc_plus4_w_q;
    rd_w_d         = update_w ? RDM        : rd_w_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      wait_cnt_q     <= '0;
      reg_write_w_q  <= '0;
      result_src_w_q <= '0;
      read_data_w_q  <= '0;
      alu_result_w_q <= '0;
      pc_plus4_w_q   <= '0;
      rd_w_q         <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      read_data_w_q  <= read_data_w_d;
      alu_result_w_q <= alu_result_w_d;
      pc_plus4_w_q   <= pc_plus4_w_d;
      rd_w_q         <= rd_w_d;
    end
  end

  assign RegWriteW  = reg_write_w_q;
  assign ResultSrcW = result_src_w_q;
  assign ReadDataW  = read_data_w_q;
  assign ALUResultW = alu_result_w_q;
  assign PCPlus4W   = pc_plus4_w_q;
  assign RDW        = rd_w_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios plus randomized
// operation streams checked against a transaction-level model.
`timescale 1ns/1ps
module tb_memory_access_stage;
  import memory_access_stage_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  RegWriteM;
  logic [1:0]  ResultSrcM, MemWriteM;
  logic [2:0]  LoadTypeM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RDM;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [3:0]  dmem_wstrb;
  logic        Stall_M, misalign_M, bus_err_M;
  logic [2:0]  RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
  logic [4:0]  RDW;
  state_e      state_dbg;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0]  rw;
    logic [1:0]  rs;
    logic        rd_known;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } wb_t;

  wb_t exp_q[$];
  wb_t exp_w;
  logic [2:0] lt_tab [5];

  memory_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .LoadTypeM(LoadTypeM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RDM(RDM),
    .dmem_addr(dmem_addr), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .Stall_M(Stall_M), .misalign_M(misalign_M),
    .bus_err_M(bus_err_M), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ReadDataW(ReadDataW), .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W),
    .RDW(RDW), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not terminate");
  end

  // Reference model helpers
  function automatic int access_bytes(input logic [1:0] mw, input logic [2:0] lt);
    if (mw != MEM_NONE) return (mw == MEM_BYTE) ? 1 : (mw == MEM_HALF) ? 2 : 4;
    return (lt[1:0] == 2'b00) ? 1 : (lt[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [31:0] a,
                                             input logic [31:0] rdata);
    int n;
    logic [31:0] v;
    n = access_bytes(MEM_NONE, lt);
    if (n == 4) return rdata;
    v = (rdata >> (8 * a[1:0])) & ((32'd1 << (8 * n)) - 32'd1);
    if (!lt[2] && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  // Driver tasks
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [2:0] rw, input logic [1:0] rs, input logic [1:0] mw,
                          input logic [2:0] lt, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] pc, input logic [4:0] rd);
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; LoadTypeM = lt;
    ALUResultM = a; WriteDataM = wd; PCPlus4M = pc; RDM = rd;
  endtask

  task automatic drive_nop;
    drive_op(3'b000, RES_ALU, MEM_NONE, LT_LW, 32'h0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic test_reset;
    rst = 1'b1; drive_nop(); dmem_ready = 1'b0; dmem_rdata = 32'h0;
    step; step;
    checks++; if (RegWriteW !== 3'b000) begin failures++; $display("FAIL reset_regwrite got=%0h exp=0", RegWriteW); end
    checks++; if (ResultSrcW !== 2'b00) begin failures++; $display("FAIL reset_resultsrc got=%0h exp=0", ResultSrcW); end
    checks++; if (ReadDataW !== 32'h0) begin failures++; $display("FAIL reset_readdata got=%0h exp=0", ReadDataW); end
    checks++; if (ALUResultW !== 32'h0) begin failures++; $display("FAIL reset_aluresult got=%0h exp=0", ALUResultW); end
    checks++; if (PCPlus4W !== 32'h0) begin failures++; $display("FAIL reset_pcplus4 got=%0h exp=0", PCPlus4W); end
    checks++; if (RDW !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0h exp=0", RDW); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    drive_op(3'b001, RES_MEM, MEM_NONE, LT_LW, 32'h40, 32'h0, 32'h44, 5'd3);
    #1;
    checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", dmem_req); end
    checks++; if (Stall_M !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", Stall_M); end
    checks++; if (misalign_M !== 1'b0 || bus_err_M !== 1'b0) begin failures++; $display("FAIL reset_exc got=%0b%0b exp=00", misalign_M, bus_err_M); end
    step;
    checks++; if (RegWriteW !== 3'b000) begin failures++; $display("FAIL reset_hold_regwrite got=%0h exp=0", RegWriteW); end
    rst = 1'b0; drive_nop();
  endtask

  task automatic test_store_word;
    drive_op(3'b001, RES_ALU, MEM_NONE, LT_LW, 32'h1234, 32'h0, 32'h1000, 5'd7);
    #1;
    checks++; if (Stall_M !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL alu_noreq got=%0b%0b exp=00", Stall_M, dmem_req); end
    step;
    checks++; if (RegWriteW !== 3'b001 || ALUResultW !== 32'h1234 || RDW !== 5'd7 || PCPlus4W !== 32'h1000) begin
      failures++; $display("FAIL alu_wb got=%0h/%0h/%0h/%0h exp=1/1234/7/1000", RegWriteW, ALUResultW, RDW, PCPlus4W); end
    drive_op(3'b000, RES_ALU, MEM_WORD, LT_LW, 32'h104, 32'hDEADBEEF, 32'h2000, 5'd0);
    dmem_ready = 1'b1;
    #1;
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin failures++; $display("FAIL sw_req got=%0b%0b exp=11", dmem_req, dmem_we); end
    checks++; if (dmem_addr !== 32'h104) begin failures++; $display("FAIL sw_addr got=%0h exp=104", dmem_addr); end
    checks++; if (dmem_wstrb !== 4'b1111) begin failures++; $display("FAIL sw_wstrb got=%0b exp=1111", dmem_wstrb); end
    checks++; if (dmem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%0h exp=deadbeef", dmem_wdata); end
    checks++; if (Stall_M !== 1'b0) begin failures++; $display("FAIL sw_stall got=%0b exp=0", Stall_M); end
    step;
    drive_nop(); dmem_ready = 1'b0;
    #1;
    checks++; if (Stall_M !== 1'b0) begin failures++; $display("FAIL sw_stall_after got=%0b exp=0", Stall_M); end
    checks++; if (RegWriteW !== 3'b000 || ALUResultW !== 32'h104) begin failures++; $display("FAIL sw_wb got=%0h/%0h exp=0/104", RegWriteW, ALUResultW); end
  endtask

  task automatic test_load_byte_wait;
    int stalls, bubbles;
    logic done;
    drive_op(3'b001, RES_ALU, MEM_NONE, LT_LW, 32'h55, 32'h0, 32'h0, 5'd1);
    step;
    drive_op(3'b001, RES_MEM, MEM_NONE, LT_LB, 32'h103, 32'h0, 32'h3000, 5'd9);
    stalls = 0; bubbles = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      dmem_ready = (c == 3);
      dmem_rdata = (c == 3) ? 32'h8012_3456 : 32'h0;
      #1;
      if (c == 0) begin
        checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100) begin failures++; $display("FAIL lb_req got=%0b/%0h exp=1/100", dmem_req, dmem_addr); end
      end
      if (Stall_M === 1'b1) begin
        stalls++;
        step;
        if (RegWriteW === 3'b000) bubbles++;
      end else begin
        done = 1'b1;
        step;
      end
    end
    drive_nop(); dmem_ready = 1'b0;
    checks++; if (!done) begin failures++; $display("FAIL lb_complete got=0 exp=1"); end
    checks++; if (stalls != 3) begin failures++; $display("FAIL lb_stall_cycles got=%0d exp=3", stalls); end
    checks++; if (bubbles != 3) begin failures++; $display("FAIL lb_bubbles got=%0d exp=3", bubbles); end
    checks++; if (ReadDataW !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_readdata got=%0h exp=ffffff80", ReadDataW); end
    checks++; if (RegWriteW !== 3'b001 || RDW !== 5'd9) begin failures++; $display("FAIL lb_wb got=%0h/%0h exp=1/9", RegWriteW, RDW); end
  endtask

  task automatic test_misaligned;
    drive_op(3'b010, RES_ALU, MEM_NONE, LT_LW, 32'h5555, 32'h0, 32'h0, 5'd2);
    step;
    drive_op(3'b000, RES_ALU, MEM_HALF, LT_LW, 32'h101, 32'hABCD, 32'h4000, 5'd1);
    dmem_ready = 1'b1;
    #1;
    checks++; if (misalign_M !== 1'b1) begin failures++; $display("FAIL sh_misalign got=%0b exp=1", misalign_M); end
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin failures++; $display("FAIL sh_noreq got=%0b%0b exp=00", dmem_req, dmem_we); end
    checks++; if (Stall_M !== 1'b0) begin failures++; $display("FAIL sh_stall got=%0b exp=0", Stall_M); end
    step;
    checks++; if (RegWriteW !== 3'b000 || ALUResultW !== 32'h5555) begin failures++; $display("FAIL sh_bubble got=%0h/%0h exp=0/5555", RegWriteW, ALUResultW); end
    drive_op(3'b001, RES_MEM, MEM_NONE, LT_LW, 32'h102, 32'h0, 32'h4004, 5'd6);
    #1;
    checks++; if (misalign_M !== 1'b1 || dmem_req !== 1'b0) begin failures++; $display("FAIL lw_misalign got=%0b%0b exp=10", misalign_M, dmem_req); end
    step;
    checks++; if (RegWriteW !== 3'b000) begin failures++; $display("FAIL lw_misalign_bubble got=%0h exp=0", RegWriteW); end
    drive_nop(); dmem_ready = 1'b0;
    #1;
    checks++; if (misalign_M !== 1'b0) begin failures++; $display("FAIL misalign_pulse got=%0b exp=0", misalign_M); end
    step;
  endtask

  task automatic test_lhu;
    drive_op(3'b001, RES_MEM, MEM_NONE, LT_LHU, 32'h102, 32'h0, 32'h6000, 5'd11);
    dmem_ready = 1'b1; dmem_rdata = 32'hBEEF1234;
    #1;
    checks++; if (Stall_M !== 1'b0 || dmem_addr !== 32'h100) begin failures++; $display("FAIL lhu_issue got=%0b/%0h exp=0/100", Stall_M, dmem_addr); end
    step;
    checks++; if (ReadDataW !== 32'h0000BEEF) begin failures++; $display("FAIL lhu_readdata got=%0h exp=0000beef", ReadDataW); end
    drive_op(3'b001, RES_MEM, MEM_NONE, LT_LH, 32'h102, 32'h0, 32'h6004, 5'd12);
    step;
    checks++; if (ReadDataW !== 32'hFFFFBEEF) begin failures++; $display("FAIL lh_readdata got=%0h exp=ffffbeef", ReadDataW); end
    drive_nop(); dmem_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int stalls, errs, err_cyc;
    logic ended;
    drive_op(3'b001, RES_ALU, MEM_NONE, LT_LW, 32'h99, 32'h0, 32'h0, 5'd1);
    step;
    drive_op(3'b001, RES_MEM, MEM_NONE, LT_LW, 32'h200, 32'h0, 32'h5000, 5'd4);
    dmem_ready = 1'b0;
    stalls = 0; errs = 0; err_cyc = -1; ended = 1'b0;
    for (int c = 0; c < TIMEOUT + 10 && !ended; c++) begin
      #1;
      if (bus_err_M === 1'b1) begin
        err_cyc = c; ended = 1'b1;
        checks++; if (Stall_M !== 1'b0) begin failures++; $display("FAIL to_err_stall got=%0b exp=0", Stall_M); end
      end else if (Stall_M === 1'b1) begin
        stalls++;
      end else begin
        ended = 1'b1;
      end
      step;
    end
    drive_nop();
    #1;
    checks++; if (err_cyc != TIMEOUT) begin failures++; $display("FAIL to_err_cycle got=%0d exp=%0d", err_cyc, TIMEOUT); end
    checks++; if (stalls != TIMEOUT) begin failures++; $display("FAIL to_stall_cycles got=%0d exp=%0d", stalls, TIMEOUT); end
    checks++; if (bus_err_M !== 1'b0 || Stall_M !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL to_after got=%0b%0b%0b exp=000", bus_err_M, Stall_M, dmem_req); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL to_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    checks++; if (RegWriteW !== 3'b000) begin failures++; $display("FAIL to_bubble got=%0h exp=0", RegWriteW); end
    step;
    drive_op(3'b001, RES_MEM, MEM_NONE, LT_LW, 32'h204, 32'h0, 32'h5004, 5'd8);
    stalls = 0; errs = 0;
    for (int c = 0; c <= TIMEOUT; c++) begin
      dmem_ready = (c == TIMEOUT);
      dmem_rdata = 32'h1234_5678;
      #1;
      if (bus_err_M === 1'b1) errs++;
      if (Stall_M === 1'b1) stalls++;
      step;
    end
    drive_nop(); dmem_ready = 1'b0;
    checks++; if (errs != 0) begin failures++; $display("FAIL tie_err got=%0d exp=0", errs); end
    checks++; if (stalls != TIMEOUT) begin failures++; $display("FAIL tie_stalls got=%0d exp=%0d", stalls, TIMEOUT); end
    checks++; if (RegWriteW !== 3'b001 || ReadDataW !== 32'h1234_5678) begin failures++; $display("FAIL tie_wb got=%0h/%0h exp=1/12345678", RegWriteW, ReadDataW); end
  endtask

  task automatic test_reset_in_wait;
    int errs;
    drive_op(3'b011, RES_ALU, MEM_NONE, LT_LW, 32'h777, 32'h0, 32'h7000, 5'd13);
    step;
    drive_op(3'b001, RES_MEM, MEM_NONE, LT_LW, 32'h300, 32'h0, 32'h7004, 5'd14);
    dmem_ready = 1'b0;
    step; step;
    checks++; if (state_dbg !== ST_WAIT) begin failures++; $display("FAIL rw_in_wait got=%0d exp=%0d", state_dbg, ST_WAIT); end
    rst = 1'b1;
    #1;
    checks++; if (dmem_req !== 1'b0 || Stall_M !== 1'b0 || bus_err_M !== 1'b0) begin failures++; $display("FAIL rw_during got=%0b%0b%0b exp=000", dmem_req, Stall_M, bus_err_M); end
    step;
    rst = 1'b0; drive_nop();
    #1;
    checks++; if (RegWriteW !== 3'b0 || ResultSrcW !== 2'b0 || ReadDataW !== 32'h0 || ALUResultW !== 32'h0 || PCPlus4W !== 32'h0 || RDW !== 5'd0) begin
      failures++; $display("FAIL rw_wb_clear got=%0h/%0h/%0h/%0h/%0h/%0h exp=all0", RegWriteW, ResultSrcW, ReadDataW, ALUResultW, PCPlus4W, RDW); end
    checks++; if (state_dbg !== ST_IDLE || dmem_req !== 1'b0 || Stall_M !== 1'b0) begin failures++; $display("FAIL rw_idle got=%0d%0b%0b exp=000", state_dbg, dmem_req, Stall_M); end
    errs = 0;
    for (int c = 0; c < TIMEOUT + 2; c++) begin
      if (bus_err_M === 1'b1 || misalign_M === 1'b1) errs++;
      step;
    end
    checks++; if (errs != 0) begin failures++; $display("FAIL rw_no_err got=%0d exp=0", errs); end
  endtask

  task automatic test_random;
    rst = 1'b1; drive_nop(); dmem_ready = 1'b0;
    step;
    rst = 1'b0;
    exp_w = '0; exp_w.rd_known = 1'b1;
    for (int n = 0; n < 60; n++) begin
      int kind, lat, nb, stall_exp, r;
      logic [1:0] mw, rs;
      logic [2:0] lt, rw;
      logic [31:0] a, wd, pc, rdv;
      logic [4:0] rd;
      logic is_mem, is_store, mis, err_exp, done;
      wb_t e;
      kind = $urandom_range(0, 3);
      rw = 3'($urandom_range(1, 7)); rd = 5'($urandom); a = $urandom; wd = $urandom; pc = $urandom;
      mw = MEM_NONE; rs = RES_ALU; lt = lt_tab[$urandom_range(0, 4)];
      if (kind == 1) rs = RES_PC4;
      if (kind == 2) rs = RES_MEM;
      if (kind == 3) begin mw = 2'($urandom_range(1, 3)); rw = 3'b000; end
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      lat = (r < 7) ? (r % 4) : (r == 7) ? TIMEOUT : TIMEOUT + 3;
      is_store = mw != MEM_NONE;
      is_mem = is_store || (rs == RES_MEM);
      nb = access_bytes(mw, lt);
      mis = is_mem && ((a & 32'(nb - 1)) != 32'h0);
      err_exp = is_mem && !mis && (lat > TIMEOUT);
      stall_exp = (!is_mem || mis) ? 0 : (lat < TIMEOUT) ? lat : TIMEOUT;
      drive_op(rw, rs, mw, lt, a, wd, pc, rd);
      done = 1'b0;
      for (int c = 0; c <= TIMEOUT + 4 && !done; c++) begin
        rdv = $urandom; dmem_rdata = rdv; dmem_ready = (c == lat);
        #1;
        if (c == 0) begin
          checks++; if (dmem_req !== (is_mem && !mis)) begin failures++; $display("FAIL rnd_req n=%0d got=%0b exp=%0b", n, dmem_req, is_mem && !mis); end
          if (is_store && !mis) begin
            checks++; if (dmem_addr !== (a & 32'hFFFF_FFFC)) begin failures++; $display("FAIL rnd_addr n=%0d got=%0h exp=%0h", n, dmem_addr, a & 32'hFFFF_FFFC); end
            checks++; if (dmem_wstrb !== 4'(((1 << nb) - 1) << a[1:0])) begin failures++; $display("FAIL rnd_wstrb n=%0d got=%0b exp=%0b", n, dmem_wstrb, 4'(((1 << nb) - 1) << a[1:0])); end
            checks++;
            if (dmem_wdata !== ((nb == 1) ? 32'(wd[7:0]) * 32'h01010101 : (nb == 2) ? 32'(wd[15:0]) * 32'h00010001 : wd)) begin
              failures++; $display("FAIL rnd_wdata n=%0d got=%0h size=%0d wd=%0h", n, dmem_wdata, nb, wd); end
          end
        end
        if (c < stall_exp) begin
          checks++; if (Stall_M !== 1'b1) begin failures++; $display("FAIL rnd_stall n=%0d c=%0d got=%0b exp=1", n, c, Stall_M); end
          step;
          checks++; if (RegWriteW !== 3'b000) begin failures++; $display("FAIL rnd_bubble n=%0d got=%0h exp=0", n, RegWriteW); end
        end else begin
          checks++; if (Stall_M !== 1'b0) begin failures++; $display("FAIL rnd_stall_end n=%0d got=%0b exp=0", n, Stall_M); end
          checks++; if (bus_err_M !== err_exp) begin failures++; $display("FAIL rnd_buserr n=%0d got=%0b exp=%0b", n, bus_err_M, err_exp); end
          checks++; if (misalign_M !== mis) begin failures++; $display("FAIL rnd_misalign n=%0d got=%0b exp=%0b", n, misalign_M, mis); end
          if (mis || err_exp) begin
            exp_w.rw = 3'b000;
          end else begin
            exp_w.rw = rw; exp_w.rs = rs; exp_w.alu = a; exp_w.pc4 = pc; exp_w.rd = rd;
            exp_w.rd_known = (rs == RES_MEM);
            exp_w.rdata = (rs == RES_MEM) ? model_load(lt, a, rdv) : 32'h0;
          end
          exp_q.push_back(exp_w);
          step;
          done = 1'b1;
        end
      end
      checks++; if (exp_q.size() == 0) begin failures++; $display("FAIL rnd_no_result n=%0d got=0 exp=1", n); end
      else begin
        e = exp_q.pop_front();
        checks++; if (RegWriteW !== e.rw) begin failures++; $display("FAIL rnd_w_regwrite n=%0d got=%0h exp=%0h", n, RegWriteW, e.rw); end
        checks++; if (ResultSrcW !== e.rs || RDW !== e.rd) begin failures++; $display("FAIL rnd_w_ctrl n=%0d got=%0h/%0h exp=%0h/%0h", n, ResultSrcW, RDW, e.rs, e.rd); end
        checks++; if (ALUResultW !== e.alu || PCPlus4W !== e.pc4) begin failures++; $display("FAIL rnd_w_data n=%0d got=%0h/%0h exp=%0h/%0h", n, ALUResultW, PCPlus4W, e.alu, e.pc4); end
        if (e.rd_known) begin
          checks++; if (ReadDataW !== e.rdata) begin failures++; $display("FAIL rnd_w_readdata n=%0d got=%0h exp=%0h", n, ReadDataW, e.rdata); end
        end
      end
    end
    drive_nop(); dmem_ready = 1'b0;
  endtask

  initial begin
    lt_tab[0] = LT_LB; lt_tab[1] = LT_LH; lt_tab[2] = LT_LW; lt_tab[3] = LT_LBU; lt_tab[4] = LT_LHU;
    rst = 1'b1;
    drive_nop();
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    test_reset();
    test_store_word();
    test_load_byte_wait();
    test_misaligned();
    test_lhu();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
